seven_seg_capture: RTL and testbench

//  Receive-side counterpart of the multiplexed 7-seg driver. Samples the active-low seg/an scan, decodes each

---
 rtl/seven_seg_pkg.sv | 62 ++++++
 rtl/seven_seg_capture_if.sv | 23 ++
 rtl/seven_seg_pattern_decode.sv | 29 ++
 rtl/seven_seg_capture.sv | 174 +++++++++++++++++
 tb/tb_seven_seg_capture.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: active-low segment patterns, code values, anode constants,
// plus helpers for frame classification. Also used by the display driver encoder.
package seven_seg_pkg;

    // Patterns are active low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_ERR  = 7'h06;

    localparam logic [3:0] CODE_DASH = 4'hA;
    localparam logic [3:0] CODE_ERR  = 4'hE;
    localparam logic [3:0] CODE_BAD  = 4'hF;

    localparam logic [3:0] AN_D0    = 4'b1110;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    typedef enum logic [1:0] {
        KIND_NUM   = 2'd0,
        KIND_DASH  = 2'd1,
        KIND_ERR   = 2'd2,
        KIND_OTHER = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_WAIT   = 2'd3
    } cap_state_t;

    function automatic logic [3:0] an_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        return ~oh;
    endfunction

    function automatic logic all_numeric(input logic [15:0] f);
        return (f[3:0] <= 4'd9) && (f[7:4] <= 4'd9) && (f[11:8] <= 4'd9) && (f[15:12] <= 4'd9);
    endfunction

    function automatic logic [13:0] codes_to_value(input logic [15:0] f);
        return 14'(f[15:12]) * 14'd1000 + 14'(f[11:8]) * 14'd100
             + 14'(f[7:4]) * 14'd10 + 14'(f[3:0]);
    endfunction

    function automatic kind_t frame_kind(input logic [15:0] f, input logic num);
        if (f == {4{CODE_DASH}})     return KIND_DASH;
        else if (f == {4{CODE_ERR}}) return KIND_ERR;
        else if (num)                return KIND_NUM;
        else                         return KIND_OTHER;
    endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Scan inputs and published-frame outputs of the 7-segment capture block.
interface seven_seg_capture_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [13:0] value;
    logic        num_ok;
    logic [1:0]  kind;
    logic        frame_valid;
    logic        seq_err;
    logic        timeout;
    logic        bad_seg;

    modport master (
        output seg, an,
        input  digits, value, num_ok, kind, frame_valid, seq_err, timeout, bad_seg
    );

    modport slave (
        input  seg, an,
        output digits, value, num_ok, kind, frame_valid, seq_err, timeout, bad_seg
    );
endinterface

// File: rtl/seven_seg_pattern_decode.sv
// Combinational 7-segment pattern to 4-bit code decoder; undecodable patterns give
// CODE_BAD and raise bad.
module seven_seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       bad
);
    always_comb begin
        code = CODE_BAD;
        bad  = 1'b0;
        case (seg)
            SEG_0:    code = 4'h0;
            SEG_1:    code = 4'h1;
            SEG_2:    code = 4'h2;
            SEG_3:    code = 4'h3;
            SEG_4:    code = 4'h4;
            SEG_5:    code = 4'h5;
            SEG_6:    code = 4'h6;
            SEG_7:    code = 4'h7;
            SEG_8:    code = 4'h8;
            SEG_9:    code = 4'h9;
            SEG_DASH: code = CODE_DASH;
            SEG_ERR:  code = CODE_ERR;
            default:  bad  = 1'b1;
        endcase
    end
endmodule

// File: rtl/seven_seg_capture.sv
// Samples a multiplexed active-low 7-seg scan, rebuilds 4-digit frames and publishes a frame
// once it has repeated STABLE_FRAMES times in a row.
//   state  | meaning
//   SYNC   | waiting for digit0 anode to start a frame
//   SETTLE | anode just changed, let seg lines settle
//   SAMPLE | capture decoded digit; complete frame on digit3
//   WAIT   | waiting for the next anode in scan order
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned STABLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 262144
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_capture_if.slave bus
);
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned STB_W = $clog2(STABLE_FRAMES + 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_FRAMES);

    cap_state_t       state_q, state_d;
    logic [1:0]       pos_q, pos_d;
    logic [SET_W-1:0] set_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [3:0]       an_last_q;
    logic [3:0]       frame_buf_q [3];
    logic [15:0]      prev_frame_q;
    logic [STB_W-1:0] stable_cnt_q, stable_nxt;

    logic [15:0] digits_q;
    logic [13:0] value_q;
    logic        num_ok_q;
    kind_t       kind_q;
    logic        frame_valid_q, seq_err_q, timeout_q, bad_seg_q;

    logic [3:0]  code;
    logic        code_bad;
    logic        an_change, set_ld, seq_err_d, timeout_d;
    logic        frame_done, match, publish, num_now;
    logic [15:0] frame_now;

    seven_seg_pattern_decode u_decode (
        .seg  (bus.seg),
        .code (code),
        .bad  (code_bad)
    );

    // Blank anode periods carry no information, so they never count as a change.
    assign an_change = (bus.an != AN_BLANK) && (bus.an != an_last_q);

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        set_ld    = 1'b0;
        seq_err_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (bus.an == AN_D0) begin
                    state_d = ST_SETTLE;
                    pos_d   = 2'd0;
                    set_ld  = 1'b1;
                end
            end
            default: begin
                if (an_change) begin
                    if (bus.an == an_onehot(pos_q + 2'd1)) begin
                        state_d = ST_SETTLE;
                        pos_d   = pos_q + 2'd1;
                        set_ld  = 1'b1;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = ST_SYNC;
                    end
                end else if (state_q == ST_SAMPLE) begin
                    state_d = ST_WAIT;
                end else if (to_cnt_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_SYNC;
                end else if (state_q == ST_SETTLE && set_cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end
            end
        endcase
    end

    always_comb begin
        frame_now  = {code, frame_buf_q[2], frame_buf_q[1], frame_buf_q[0]};
        frame_done = (state_q == ST_SAMPLE) && (pos_q == 2'd3);
        match      = (frame_now == prev_frame_q);
        num_now    = all_numeric(frame_now);
        stable_nxt = STB_W'(1);
        if (match) begin
            stable_nxt = (stable_cnt_q == STB_MAX) ? STB_MAX : stable_cnt_q + STB_W'(1);
        end
        // Publish only on the transition into a stable run, not while it stays saturated.
        publish = frame_done && !seq_err_d && (stable_nxt == STB_MAX)
                  && !(match && stable_cnt_q == STB_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SYNC;
            pos_q         <= 2'd0;
            set_cnt_q     <= SET_LOAD;
            to_cnt_q      <= TO_LOAD;
            an_last_q     <= AN_BLANK;
            frame_buf_q   <= '{CODE_BAD, CODE_BAD, CODE_BAD};
            prev_frame_q  <= 16'hFFFF;
            stable_cnt_q  <= '0;
            digits_q      <= 16'hFFFF;
            value_q       <= '0;
            num_ok_q      <= 1'b0;
            kind_q        <= KIND_OTHER;
            frame_valid_q <= 1'b0;
            seq_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
            bad_seg_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            if (bus.an != AN_BLANK) an_last_q <= bus.an;

            if (set_ld)                                         set_cnt_q <= SET_LOAD;
            else if (state_q == ST_SETTLE && set_cnt_q != '0)   set_cnt_q <= set_cnt_q - SET_W'(1);

            if (state_q == ST_SYNC || an_change) to_cnt_q <= TO_LOAD;
            else if (to_cnt_q != '0)              to_cnt_q <= to_cnt_q - TO_W'(1);

            if (state_q == ST_SAMPLE) begin
                case (pos_q)
                    2'd0:    frame_buf_q[0] <= code;
                    2'd1:    frame_buf_q[1] <= code;
                    2'd2:    frame_buf_q[2] <= code;
                    default: ;
                endcase
            end

            if (seq_err_d || timeout_d) begin
                stable_cnt_q <= '0;
            end else if (frame_done) begin
                stable_cnt_q <= stable_nxt;
                prev_frame_q <= frame_now;
            end

            if (publish) begin
                digits_q <= frame_now;
                num_ok_q <= num_now;
                value_q  <= num_now ? codes_to_value(frame_now) : 14'd0;
                kind_q   <= frame_kind(frame_now, num_now);
            end

            frame_valid_q <= publish;
            seq_err_q     <= seq_err_d;
            timeout_q     <= timeout_d;
            bad_seg_q     <= (state_q == ST_SAMPLE) && code_bad;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.value       = value_q;
    assign bus.num_ok      = num_ok_q;
    assign bus.kind        = kind_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.timeout     = timeout_q;
    assign bus.bad_seg     = bad_seg_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: table of scanned frames plus hand-written
// timeout, sequence-error, bad-pattern and mid-frame reset sequences.
module tb_seven_seg_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_capture_if bus ();

    seven_seg_capture #(
        .SETTLE_CYCLES  (4),
        .STABLE_FRAMES  (2),
        .TIMEOUT_CYCLES (512)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] frame;
        logic [15:0] digits;
        int          value;
        logic        num_ok;
        logic [1:0]  kind;
    } vec_t;

    vec_t vecs [8];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fv_n = 0, se_n = 0, to_n = 0, bs_n = 0;
    int fv_cyc = 0, to_cyc = 0;
    int last_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_valid) begin
            fv_n   <= fv_n + 1;
            fv_cyc <= cyc;
        end
        if (bus.seq_err) se_n <= se_n + 1;
        if (bus.timeout) begin
            to_n   <= to_n + 1;
            to_cyc <= cyc;
        end
        if (bus.bad_seg) bs_n <= bs_n + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] enc(input logic [3:0] c);
        case (c)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h3F;
            4'hE: return 7'h06;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_digit(input int idx, input logic [3:0] c, input int n);
        logic [3:0] a;
        @(posedge clk);
        #1;
        a          = 4'b0001 << idx;
        bus.an     = ~a;
        bus.seg    = enc(c);
        last_start = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    // Returns the cycle at which digit3 was driven.
    task automatic scan(input logic [15:0] f, output int t3);
        for (int i = 0; i < 4; i++) begin
            drive_digit(i, f[i*4 +: 4], 64);
            if (i == 3) t3 = last_start;
        end
        @(negedge clk);
    endtask

    initial begin
        int t3, fv0, se0, to0, bs0, t1;
        vecs[0] = '{16'h0097, 16'h0097,   97, 1'b1, 2'd0};
        vecs[1] = '{16'h0101, 16'h0101,  101, 1'b1, 2'd0};
        vecs[2] = '{16'hAAAA, 16'hAAAA,    0, 1'b0, 2'd1};
        vecs[3] = '{16'hAAA0, 16'hAAA0,    0, 1'b0, 2'd3};
        vecs[4] = '{16'hEEEE, 16'hEEEE,    0, 1'b0, 2'd2};
        vecs[5] = '{16'h9999, 16'h9999, 9999, 1'b1, 2'd0};
        vecs[6] = '{16'h1234, 16'h1234, 1234, 1'b1, 2'd0};
        vecs[7] = '{16'h0097, 16'h0097,   97, 1'b1, 2'd0};

        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_digits", bus.digits, 16'hFFFF);
        chk("rst_value", bus.value, 0);
        chk("rst_num_ok", bus.num_ok, 0);
        chk("rst_kind", bus.kind, 3);
        chk("rst_fv", bus.frame_valid, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            fv0 = fv_n;
            scan(vecs[i].frame, t3);
            chk($sformatf("v%0d_nopulse_first", i), fv_n - fv0, 0);
            scan(vecs[i].frame, t3);
            chk($sformatf("v%0d_pulse", i), fv_n - fv0, 1);
            chk($sformatf("v%0d_latency", i), fv_cyc, t3 + 6);
            chk($sformatf("v%0d_digits", i), bus.digits, vecs[i].digits);
            chk($sformatf("v%0d_value", i), bus.value, vecs[i].value);
            chk($sformatf("v%0d_num_ok", i), bus.num_ok, vecs[i].num_ok);
            chk($sformatf("v%0d_kind", i), bus.kind, vecs[i].kind);
            scan(vecs[i].frame, t3);
            chk($sformatf("v%0d_no_repeat", i), fv_n - fv0, 1);
        end
        chk("table_seq_err", se_n, 0);
        chk("table_timeout", to_n, 0);
        chk("table_bad_seg", bs_n, 0);

        // Stalled scan on digit1
        fv0 = fv_n;
        to0 = to_n;
        drive_digit(0, 4'h7, 64);
        drive_digit(1, 4'h9, 600);
        t1 = last_start;
        @(negedge clk);
        chk("to_count", to_n - to0, 1);
        chk("to_cycle", to_cyc, t1 + 513);
        chk("to_hold_digits", bus.digits, 16'h0097);
        chk("to_hold_kind", bus.kind, 0);
        chk("to_no_fv", fv_n - fv0, 0);
        scan(16'h0097, t3);
        chk("to_resync_first", fv_n - fv0, 0);
        scan(16'h0097, t3);
        chk("to_republish", fv_n - fv0, 1);
        chk("to_republish_lat", fv_cyc, t3 + 6);

        // Out-of-order anode, then a frame with an undecodable digit2
        se0 = se_n;
        bs0 = bs_n;
        fv0 = fv_n;
        drive_digit(0, 4'h0, 64);
        drive_digit(2, 4'h0, 20);
        @(negedge clk);
        chk("seq_err_pulse", se_n - se0, 1);
        chk("seq_err_hold", bus.digits, 16'h0097);
        scan(16'h1F23, t3);
        scan(16'h1F23, t3);
        chk("bad_seg_count", bs_n - bs0, 2);
        chk("bad_fv", fv_n - fv0, 1);
        chk("bad_digits", bus.digits, 16'h1F23);
        chk("bad_kind", bus.kind, 3);
        chk("bad_value", bus.value, 0);
        chk("bad_num_ok", bus.num_ok, 0);

        // Reset in the middle of a frame
        fv0 = fv_n;
        se0 = se_n;
        to0 = to_n;
        drive_digit(0, 4'h1, 64);
        drive_digit(1, 4'h0, 30);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_digits", bus.digits, 16'hFFFF);
        chk("mid_rst_kind", bus.kind, 3);
        chk("mid_rst_value", bus.value, 0);
        chk("mid_rst_fv", bus.frame_valid, 0);
        rst = 1'b0;
        drive_digit(1, 4'h0, 20);
        scan(16'h0097, t3);
        chk("post_rst_first", fv_n - fv0, 0);
        scan(16'h0097, t3);
        chk("post_rst_pulse", fv_n - fv0, 1);
        chk("post_rst_digits", bus.digits, 16'h0097);
        chk("post_rst_seq", se_n - se0, 0);
        chk("post_rst_to", to_n - to0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
